inv_sub_bytes_seq: RTL and testbench

Sequential InvSubBytes engine for the AES decryption datapath. It is the inverse counterpart of the key-expansion forward S-box lookup. It accepts one 128-bit AES state and substitutes all 16 bytes through the inverse S-box. The work runs four bytes per cycle, using two dual-read-port synchronous ROMs (`generic_init_mem_2r`, 8x256, 1-cycle read latency). It sits between InvShiftRows and AddRoundKey in the decryption round controller.

---
 rtl/inv_sub_bytes_seq.sv | 214 +++++++++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes engine.
// Substitutes the 16 bytes of one 128-bit state through the inverse S-box,
// four bytes per cycle, using two dual-read synchronous ROMs.
// Result words land in data_out progressively; done_out qualifies the result.

// Dual-read-port synchronous ROM, 8x256, one-cycle read latency.
// The image is the AES inverse S-box. An empty INIT_FILE name means no
// image is loaded, and the memory then reads as zero.
module generic_init_mem_2r #(
  parameter string INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       en,
  input  logic [7:0] addr_a,
  input  logic [7:0] addr_b,
  output logic [7:0] dout_a,
  output logic [7:0] dout_b
);

  localparam bit HAS_IMAGE = (INIT_FILE != "");

  // Inverse S-box image, entry 0 in the top byte.
  localparam logic [2047:0] IMAGE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] lookup(input logic [7:0] addr);
    logic [10:0] top_bit;
    top_bit = 11'd2047 - {addr, 3'b000};
    if (HAS_IMAGE) begin
      lookup = IMAGE[top_bit -: 8];
    end else begin
      lookup = 8'h00;
    end
  endfunction

  // Registered read on both ports; outputs hold while disabled.
  always_ff @(posedge clk) begin
    if (en) begin
      dout_a <= lookup(addr_a);
      dout_b <= lookup(addr_b);
    end
  end

endmodule

module inv_sub_bytes_seq #(
  parameter string INIT_FILE = "inv_sbox.init"
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [127:0] data_in,
  output logic         ready_out,
  output logic         done_out,
  output logic [127:0] data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_s;
  logic [1:0]   cnt_r;
  logic [1:0]   cnt_s;
  logic [127:0] state_q_r;
  logic         capture_s;
  logic         wr_en_s;
  logic [1:0]   wr_idx_s;
  logic         done_s;
  logic         rom_en_s;
  logic [31:0]  rd_word_s;
  logic [31:0]  rom_word_s;
  logic [7:0]   m0_a_s;
  logic [7:0]   m0_b_s;
  logic [7:0]   m1_a_s;
  logic [7:0]   m1_b_s;

  assign ready_out  = (state_r == IDLE);
  assign rom_word_s = {m0_a_s, m0_b_s, m1_a_s, m1_b_s};

  // Pick the captured word that the ROMs look up in the current RUN cycle.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    case (cnt_r)
      2'd0:    rd_word_s = state_q_r[127:96];
      2'd1:    rd_word_s = state_q_r[95:64];
      2'd2:    rd_word_s = state_q_r[63:32];
      2'd3:    rd_word_s = state_q_r[31:0];
      default: rd_word_s = 32'h0000_0000;
    endcase
  end

  // ROM m0 serves bytes 4cnt and 4cnt+1.
  generic_init_mem_2r #(.INIT_FILE(INIT_FILE)) u_rom_m0 (
    .clk    (clk_in),
    .en     (rom_en_s),
    .addr_a (rd_word_s[31:24]),
    .addr_b (rd_word_s[23:16]),
    .dout_a (m0_a_s),
    .dout_b (m0_b_s)
  );

  // ROM m1 serves bytes 4cnt+2 and 4cnt+3.
  generic_init_mem_2r #(.INIT_FILE(INIT_FILE)) u_rom_m1 (
    .clk    (clk_in),
    .en     (rom_en_s),
    .addr_a (rd_word_s[15:8]),
    .addr_b (rd_word_s[7:0]),
    .dout_a (m1_a_s),
    .dout_b (m1_b_s)
  );

  // State register and word counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  // ROM data trails the address by one cycle, so RUN cycle cnt writes
  // word cnt-1 and WB writes the final word 3.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    wr_en_s   = 1'b0;
    wr_idx_s  = 2'd0;
    done_s    = 1'b0;
    rom_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_in) begin
          state_s   = RUN;
          cnt_s     = 2'd0;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        rom_en_s = 1'b1;
        if (cnt_r != 2'd0) begin
          wr_en_s  = 1'b1;
          wr_idx_s = cnt_r - 2'd1;
        end else begin
          wr_en_s = 1'b0;
        end
        if (cnt_r == 2'd3) begin
          state_s = WB;
        end else begin
          cnt_s = cnt_r + 2'd1;
        end
      end
      WB: begin
        wr_en_s  = 1'b1;
        wr_idx_s = 2'd3;
        done_s   = 1'b1;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // Input capture, progressive result writeback and the done pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q_r <= 128'h0;
      data_out  <= 128'h0;
      done_out  <= 1'b0;
    end else begin
      if (capture_s) begin
        state_q_r <= data_in;
      end
      if (wr_en_s) begin
        case (wr_idx_s)
          2'd0:    data_out[127:96] <= rom_word_s;
          2'd1:    data_out[95:64]  <= rom_word_s;
          2'd2:    data_out[63:32]  <= rom_word_s;
          2'd3:    data_out[31:0]   <= rom_word_s;
          default: data_out         <= data_out;
        endcase
      end
      done_out <= done_s;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq. The reference inverse S-box is
// derived arithmetically (inverse affine map, then GF(2^8) inversion).
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] data_in = 128'h0;
  logic         ready;
  logic         done;
  logic [127:0] data_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0]   ref_tab [256];
  logic [127:0] last_result;

  inv_sub_bytes_seq #(.INIT_FILE("inv_sbox.init")) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .start_in  (start),
    .data_in   (data_in),
    .ready_out (ready),
    .done_out  (done),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox_calc(input logic [7:0] s);
    logic [7:0] b, inv;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(b, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = ref_tab[x[127 - 8*k -: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One full operation with latency and result checks.
  task automatic do_op(input string tag, input logic [127:0] v,
                       input bit use_lit, input logic [127:0] lit);
    int w;
    logic [127:0] exp;
    w = 0;
    while (!ready && w < 10) begin tick(); w++; end
    chk({tag, "_ready_before"}, {127'h0, ready}, 128'h1);
    exp = ref_sub(v);
    start = 1'b1; data_in = v;
    tick();
    start = 1'b0; data_in = rnd128();
    for (int k = 1; k <= 5; k++) begin
      chk({tag, "_busy"}, {126'h0, ready, done}, 128'h0);
      tick();
    end
    chk({tag, "_done_ready"}, {126'h0, ready, done}, 128'h3);
    chk({tag, "_result"}, data_out, exp);
    if (use_lit) chk({tag, "_literal"}, data_out, lit);
    last_result = exp;
    tick();
    chk({tag, "_done_clear"}, {127'h0, done}, 128'h0);
  endtask

  initial begin
    logic [127:0] exp_q[$];
    logic [127:0] v;
    int last_acc, n_acc, n_done, w;
    bit prev_done;

    for (int x = 0; x < 256; x++) ref_tab[x] = inv_sbox_calc(8'(x));

    // Reset state
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    chk("rst_ready", {127'h0, ready}, 128'h1);
    chk("rst_done", {127'h0, done}, 128'h0);
    chk("rst_data", data_out, 128'h0);

    // Directed vectors
    do_op("fips", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
          128'h193de3bea0f4e22b9ac68d2ae9f84808);
    do_op("all63", {16{8'h63}}, 1'b1, {16{8'h00}});
    do_op("all00", {16{8'h00}}, 1'b1, {16{8'h52}});
    do_op("all16", {16{8'h16}}, 1'b1, {16{8'hff}});
    do_op("order", 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
          128'h52096ad53036a538bf40a39e81f3d7fb);
    for (int i = 0; i < 4; i++) do_op("random", rnd128(), 1'b0, 128'h0);

    // Back-to-back with start held high and data changing every cycle
    last_acc = -1; n_acc = 0; n_done = 0; prev_done = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      data_in = rnd128();
      if (done) begin
        n_done++;
        chk("b2b_done_twice", {127'h0, prev_done}, 128'h0);
        if (exp_q.size() > 0) chk("b2b_result", data_out, exp_q.pop_front());
        else chk("b2b_unexpected_done", 128'h1, 128'h0);
      end
      if (ready) begin
        if (last_acc >= 0) chk("b2b_spacing", 128'(c - last_acc), 128'd6);
        exp_q.push_back(ref_sub(data_in));
        last_acc = c; n_acc++;
      end
      prev_done = done;
      tick();
    end
    start = 1'b0;
    w = 0;
    while (!done && w < 10) begin tick(); w++; end
    chk("b2b_drain_done", {127'h0, done}, 128'h1);
    if (exp_q.size() > 0) chk("b2b_last_result", data_out, exp_q.pop_front());
    n_done++;
    chk("b2b_accepts", 128'(n_acc), 128'd7);
    chk("b2b_dones", 128'(n_done), 128'd7);
    tick();

    // Reset in the middle of RUN (cnt = 2)
    v = rnd128();
    start = 1'b1; data_in = v;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_data", data_out, 128'h0);
    chk("midrst_done", {127'h0, done}, 128'h0);
    chk("midrst_ready", {127'h0, ready}, 128'h1);
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) n_done++;
      tick();
    end
    chk("midrst_no_done", 128'(n_done), 128'd0);
    do_op("after_rst", rnd128(), 1'b0, 128'h0);

    // Hold: idle with data_in toggling
    for (int c = 0; c < 20; c++) begin
      data_in = rnd128();
      chk("hold_data", data_out, last_result);
      chk("hold_done", {127'h0, done}, 128'h0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
